// File: rtl/micro_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : micro_op_sequencer
// Brief   : Buffers one decoded group and issues its micro-ops in program
//           order, holding serialized ops until all older ops have retired.
// Rev     : 1.0  initial release
// ============================================================================
module micro_op_sequencer #(
  parameter int DECODE_WIDTH     = 2,
  parameter int MICRO_OP_MAX_NUM = 3,
  parameter int ISSUE_WIDTH      = 2,
  parameter int MOP_W            = 64,
  parameter int SLOTS            = DECODE_WIDTH * MICRO_OP_MAX_NUM,
  parameter int IDX_W            = $clog2(SLOTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         inValid,
  input  logic [SLOTS-1:0]             inMopValid,
  input  logic [SLOTS-1:0]             inMopSerialized,
  input  logic [SLOTS*MOP_W-1:0]       inMop,
  output logic                         inReady,
  input  logic                         pipelineEmpty,
  output logic [ISSUE_WIDTH-1:0]       outValid,
  output logic [ISSUE_WIDTH*MOP_W-1:0] outMop,
  output logic [ISSUE_WIDTH*IDX_W-1:0] outIndex,
  input  logic                         outReady,
  output logic                         busy
);

  typedef enum logic [1:0] {
    S_EMPTY       = 2'd0,
    S_DRAIN       = 2'd1,
    S_SERIAL_WAIT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SLOTS-1:0]         r_pending;
  logic [SLOTS-1:0]         r_ser;
  logic [SLOTS*MOP_W-1:0]   r_mop;

  logic [SLOTS-1:0]         w_emit;
  logic [SLOTS-1:0]         w_pending_nxt;
  logic [SLOTS-1:0]         w_ser_nxt;
  logic                     w_accept;
  logic                     w_stop;
  logic                     w_found;
  logic                     w_head_ser;
  int                       w_lane;

  // Lane selection: walk pending from the oldest slot, packing lanes densely.
  always_comb begin
    w_emit   = '0;
    outValid = '0;
    outMop   = '0;
    outIndex = '0;
    w_lane   = 0;
    w_stop   = 1'b0;
    if (r_state != S_EMPTY) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (r_pending[k] && !w_stop) begin
          if (r_ser[k]) begin
            // A serialized op only leaves as the head, alone, once retired-empty.
            if ((w_lane == 0) && pipelineEmpty) begin
              w_emit[k]               = 1'b1;
              outValid[0]             = 1'b1;
              outMop[0 +: MOP_W]      = r_mop[k*MOP_W +: MOP_W];
              outIndex[0 +: IDX_W]    = IDX_W'(k);
            end
            w_stop = 1'b1;
          end else if (w_lane < ISSUE_WIDTH) begin
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
              if (l == w_lane) begin
                outValid[l]              = 1'b1;
                outMop[l*MOP_W +: MOP_W] = r_mop[k*MOP_W +: MOP_W];
                outIndex[l*IDX_W +: IDX_W] = IDX_W'(k);
              end
            end
            w_emit[k] = 1'b1;
            w_lane    = w_lane + 1;
          end else begin
            w_stop = 1'b1;
          end
        end
      end
    end
  end

  // Ready also when this cycle's bundle empties the buffer: zero-bubble refill.
  assign inReady  = !flush && ((r_pending == '0) || (outReady && (w_emit == r_pending)));
  assign w_accept = inValid && inReady;
  assign busy     = |r_pending;

  always_comb begin
    w_pending_nxt = r_pending;
    w_ser_nxt     = r_ser;
    w_found       = 1'b0;
    w_head_ser    = 1'b0;
    if (flush) begin
      w_pending_nxt = '0;
    end else if (w_accept) begin
      w_pending_nxt = inMopValid;
      w_ser_nxt     = inMopSerialized;
    end else if (outReady && (|outValid)) begin
      w_pending_nxt = r_pending & ~w_emit;
    end
    for (int k = 0; k < SLOTS; k++) begin
      if (w_pending_nxt[k] && !w_found) begin
        w_found    = 1'b1;
        w_head_ser = w_ser_nxt[k];
      end
    end
    if (!w_found) begin
      w_state_nxt = S_EMPTY;
    end else if (w_head_ser && !pipelineEmpty) begin
      w_state_nxt = S_SERIAL_WAIT;
    end else begin
      w_state_nxt = S_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
      r_state   <= S_EMPTY;
    end else begin
      r_pending <= w_pending_nxt;
      r_state   <= w_state_nxt;
    end
  end

  // Payload and serial flags are qualified by r_pending, so they need no reset.
  always_ff @(posedge clk) begin
    r_ser <= w_ser_nxt;
    if (w_accept) begin
      r_mop <= inMop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_micro_op_sequencer
// Brief   : Directed vector table plus randomized run against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_micro_op_sequencer;

  localparam int SLOTS = 6;
  localparam int IW    = 2;
  localparam int MOP_W = 64;
  localparam int IDX_W = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   inValid;
  logic [SLOTS-1:0]       inMopValid;
  logic [SLOTS-1:0]       inMopSerialized;
  logic [SLOTS*MOP_W-1:0] inMop;
  logic                   inReady;
  logic                   pipelineEmpty;
  logic [IW-1:0]          outValid;
  logic [IW*MOP_W-1:0]    outMop;
  logic [IW*IDX_W-1:0]    outIndex;
  logic                   outReady;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;

  micro_op_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(inValid),
    .inMopValid(inMopValid), .inMopSerialized(inMopSerialized), .inMop(inMop),
    .inReady(inReady), .pipelineEmpty(pipelineEmpty), .outValid(outValid),
    .outMop(outMop), .outIndex(outIndex), .outReady(outReady), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       iv;
    logic [5:0] mv;
    logic [5:0] sv;
    int         tag;
    logic       pe;
    logic       ordy;
    logic [1:0] e_val;
    int         e_i0;
    int         e_i1;
    logic       e_rdy;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] pay(input int tag, input int slot);
    return {tag[15:0], 16'hA5C3, 16'(slot * 257 + 11), 16'(tag * 7 + slot)};
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic fl, input logic iv,
                              input logic [5:0] mv, input logic [5:0] sv, input int tag,
                              input logic pe, input logic ordy, input logic [1:0] e_val,
                              input int e_i0, input int e_i1, input logic e_rdy,
                              input logic e_busy);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.mv = mv; v.sv = sv; v.tag = tag;
    v.pe = pe; v.ordy = ordy; v.e_val = e_val; v.e_i0 = e_i0; v.e_i1 = e_i1;
    v.e_rdy = e_rdy; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst_n, input logic fl, input logic iv, input logic [5:0] mv,
                       input logic [5:0] sv, input int tag, input logic pe, input logic ordy);
    rst             = rst_n;
    flush           = fl;
    inValid         = iv;
    inMopValid      = mv;
    inMopSerialized = sv;
    for (int k = 0; k < SLOTS; k++) inMop[k*MOP_W +: MOP_W] = pay(tag, k);
    pipelineEmpty   = pe;
    outReady        = ordy;
  endtask

  initial begin
    int   cur_tag;
    int   q[$];
    int   b[$];
    logic [5:0] m_ser;
    int   m_tag;
    logic [1:0] e_val;
    logic e_rdy;
    logic r_n, fl, iv, pe, ordy;
    logic [5:0] mv, sv;

    //        rst fl iv mv         sv         tag pe ordy e_val  i0 i1 rdy busy
    tbl.push_back(mk(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 6'b000111, 6'b000000, 1, 1, 1, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 2'b11, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 2'b01, 2, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 6'b101001, 6'b000000, 2, 1, 0, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 0, 2'b11, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 0, 2'b11, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 0, 2'b11, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 2'b11, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 1, 6'b001011, 6'b000010, 3, 0, 1, 2'b01, 5, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b01, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 2'b01, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 2'b01, 3, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 6'b000111, 6'b000000, 4, 1, 0, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 1, 1, 2'b11, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 6'b111111, 6'b000000, 5, 1, 0, 2'b01, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 6'b000011, 6'b000001, 6, 0, 1, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 6'b000110, 6'b000000, 7, 0, 1, 2'b00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 6'b000000, 6'b000000, 8, 0, 1, 2'b11, 1, 2, 1, 1));
    tbl.push_back(mk(1, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 2'b00, 0, 0, 1, 0));

    apply(0, 0, 0, '0, '0, 0, 0, 0);
    @(posedge clk); #1;

    cur_tag = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      apply(v.rst_n, v.fl, v.iv, v.mv, v.sv, v.tag, v.pe, v.ordy);
      @(negedge clk);
      chk($sformatf("vec%0d outValid", i), 64'(outValid), 64'(v.e_val));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(v.e_busy));
      chk($sformatf("vec%0d inReady", i), 64'(inReady), 64'(v.e_rdy));
      if (v.e_val[0]) begin
        chk($sformatf("vec%0d idx0", i), 64'(outIndex[2:0]), 64'(v.e_i0));
        chk($sformatf("vec%0d mop0", i), outMop[63:0], pay(cur_tag, v.e_i0));
      end
      if (v.e_val[1]) begin
        chk($sformatf("vec%0d idx1", i), 64'(outIndex[5:3]), 64'(v.e_i1));
        chk($sformatf("vec%0d mop1", i), outMop[127:64], pay(cur_tag, v.e_i1));
      end
      if (v.rst_n && !v.fl && v.iv && v.e_rdy) cur_tag = v.tag;
      @(posedge clk); #1;
    end

    // Randomized run against a queue-of-slot-indices model.
    apply(0, 0, 0, '0, '0, 0, 0, 0);
    @(posedge clk); #1;
    q.delete();
    m_ser = '0;
    m_tag = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_n  = ($urandom_range(0, 63) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      iv   = 1'(($urandom_range(0, 1)));
      mv   = 6'($urandom);
      sv   = 6'($urandom & $urandom);
      pe   = 1'(($urandom_range(0, 1)));
      ordy = ($urandom_range(0, 3) != 0);
      apply(r_n, fl, iv, mv, sv, cyc + 100, pe, ordy);
      @(negedge clk);

      b.delete();
      if (q.size() > 0) begin
        if (m_ser[q[0]]) begin
          if (pe) b.push_back(q[0]);
        end else begin
          for (int i = 0; i < q.size() && b.size() < IW && !m_ser[q[i]]; i++) b.push_back(q[i]);
        end
      end
      e_rdy = !fl && ((q.size() == 0) || (ordy && (b.size() == q.size())));
      e_val = (b.size() == 0) ? 2'b00 : (b.size() == 1) ? 2'b01 : 2'b11;

      chk("rnd outValid", 64'(outValid), 64'(e_val));
      chk("rnd busy", 64'(busy), 64'(q.size() != 0));
      chk("rnd inReady", 64'(inReady), 64'(e_rdy));
      for (int l = 0; l < b.size(); l++) begin
        chk("rnd idx", 64'(outIndex[l*IDX_W +: IDX_W]), 64'(b[l]));
        chk("rnd mop", outMop[l*MOP_W +: MOP_W], pay(m_tag, b[l]));
      end

      @(posedge clk);
      if (!r_n || fl) begin
        q.delete();
      end else if (iv && e_rdy) begin
        q.delete();
        for (int k = 0; k < SLOTS; k++) if (mv[k]) q.push_back(k);
        m_ser = sv;
        m_tag = cyc + 100;
      end else if (ordy && (b.size() > 0)) begin
        for (int l = 0; l < b.size(); l++) void'(q.pop_front());
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
